// File: rtl/wid_fifo.sv
// Write-ID FIFO for an AXI master: records each accepted AWID and presents the
// oldest one on the W channel, with a zero-latency bypass when empty.
module wid_fifo #(
   parameter int ID_WIDTH = 8,
   parameter int DEPTH    = 4
) (
   input  logic                       per_clk,
   input  logic                       pad_cpu_rst_b,
   input  logic                       wid_push,
   input  logic [ID_WIDTH-1:0]        wid_push_id,
   input  logic                       wid_pop,
   input  logic                       wid_err_clr,
   output logic [ID_WIDTH-1:0]        wid,
   output logic                       wid_vld,
   output logic                       wid_full,
   output logic                       wid_empty,
   output logic [$clog2(DEPTH):0]     wid_cnt,
   output logic                       wid_ovf_err,
   output logic                       wid_udf_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [ID_WIDTH-1:0] mem_q [DEPTH];
   logic [ID_WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                ovf_err_q, ovf_err_d;
   logic                udf_err_q, udf_err_d;

   logic empty;
   logic full;
   logic do_write;
   logic do_read;
   logic ovf_set;
   logic udf_set;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == DEPTH_C);

   // Push+pop on an empty buffer is served entirely by the bypass, so it touches no state.
   assign do_write = wid_push && ((!wid_pop && !full) || (wid_pop && !empty));
   assign do_read  = wid_pop && !empty;
   assign ovf_set  = wid_push && !wid_pop && full;
   assign udf_set  = wid_pop && !wid_push && empty;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (do_write) begin
         mem_d[wr_ptr_q] = wid_push_id;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_read) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (do_write && !do_read) begin
         cnt_d = cnt_q + CW'(1);
      end else if (do_read && !do_write) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Sticky flags: a new error in the clearing cycle takes priority.
   always_comb begin
      ovf_err_d = ovf_err_q;
      udf_err_d = udf_err_q;
      if (ovf_set) begin
         ovf_err_d = 1'b1;
      end else if (wid_err_clr) begin
         ovf_err_d = 1'b0;
      end
      if (udf_set) begin
         udf_err_d = 1'b1;
      end else if (wid_err_clr) begin
         udf_err_d = 1'b0;
      end
   end

   always_ff @(posedge per_clk or negedge pad_cpu_rst_b) begin
      if (!pad_cpu_rst_b) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         cnt_q     <= '0;
         ovf_err_q <= 1'b0;
         udf_err_q <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         cnt_q     <= cnt_d;
         ovf_err_q <= ovf_err_d;
         udf_err_q <= udf_err_d;
      end
   end

   always_comb begin
      wid = '0;
      if (!empty) begin
         wid = mem_q[rd_ptr_q];
      end else if (wid_push) begin
         wid = wid_push_id;
      end
   end

   assign wid_vld     = !empty || wid_push;
   assign wid_empty   = empty;
   assign wid_full    = full;
   assign wid_cnt     = cnt_q;
   assign wid_ovf_err = ovf_err_q;
   assign wid_udf_err = udf_err_q;

endmodule

// File: tb/tb_wid_fifo.sv
// Directed self-checking bench for wid_fifo (DEPTH=4, ID_WIDTH=8): bypass, fill/drain,
// wrap-around, overflow, underflow with clear priority and asynchronous reset.
module tb_wid_fifo;

   logic       per_clk;
   logic       pad_cpu_rst_b;
   logic       wid_push;
   logic [7:0] wid_push_id;
   logic       wid_pop;
   logic       wid_err_clr;
   logic [7:0] wid;
   logic       wid_vld;
   logic       wid_full;
   logic       wid_empty;
   logic [2:0] wid_cnt;
   logic       wid_ovf_err;
   logic       wid_udf_err;

   int checkCount = 0;
   int failCount  = 0;

   wid_fifo #(.ID_WIDTH(8), .DEPTH(4)) dut (
      .per_clk       (per_clk),
      .pad_cpu_rst_b (pad_cpu_rst_b),
      .wid_push      (wid_push),
      .wid_push_id   (wid_push_id),
      .wid_pop       (wid_pop),
      .wid_err_clr   (wid_err_clr),
      .wid           (wid),
      .wid_vld       (wid_vld),
      .wid_full      (wid_full),
      .wid_empty     (wid_empty),
      .wid_cnt       (wid_cnt),
      .wid_ovf_err   (wid_ovf_err),
      .wid_udf_err   (wid_udf_err)
   );

   initial begin
      per_clk = 1'b0;
      forever #5 per_clk = ~per_clk;
   end

   // Inputs change on the falling edge; outputs are sampled 1 ns later, well away from the rising edge.
   task automatic applyStimulus(input logic push, input logic [7:0] id, input logic pop, input logic clr);
      @(negedge per_clk);
      wid_push    = push;
      wid_push_id = id;
      wid_pop     = pop;
      wid_err_clr = clr;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   logic [7:0] expOrder [10];

   initial begin
      pad_cpu_rst_b = 1'b0;
      wid_push      = 1'b0;
      wid_push_id   = 8'h00;
      wid_pop       = 1'b0;
      wid_err_clr   = 1'b0;

      // Reset state, including the bypass path while held in reset.
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("rst_empty", 32'(wid_empty), 32'd1);
      checkOutput("rst_full", 32'(wid_full), 32'd0);
      checkOutput("rst_cnt", 32'(wid_cnt), 32'd0);
      checkOutput("rst_vld", 32'(wid_vld), 32'd0);
      checkOutput("rst_wid", 32'(wid), 32'd0);
      checkOutput("rst_ovf", 32'(wid_ovf_err), 32'd0);
      checkOutput("rst_udf", 32'(wid_udf_err), 32'd0);
      applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
      checkOutput("rst_bypass_vld", 32'(wid_vld), 32'd1);
      checkOutput("rst_bypass_wid", 32'(wid), 32'hA5);
      @(negedge per_clk);
      wid_push      = 1'b0;
      pad_cpu_rst_b = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("rst_release_cnt", 32'(wid_cnt), 32'd0);

      // Bypass: push and pop together on empty.
      applyStimulus(1'b1, 8'h3A, 1'b1, 1'b0);
      checkOutput("bypass_wid", 32'(wid), 32'h3A);
      checkOutput("bypass_vld", 32'(wid_vld), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("bypass_cnt", 32'(wid_cnt), 32'd0);
      checkOutput("bypass_vld_after", 32'(wid_vld), 32'd0);
      checkOutput("bypass_wid_after", 32'(wid), 32'd0);
      checkOutput("bypass_udf", 32'(wid_udf_err), 32'd0);

      // Fill then drain in order.
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
      checkOutput("fill_first_bypass", 32'(wid), 32'h11);
      applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("fill_full", 32'(wid_full), 32'd1);
      checkOutput("fill_cnt", 32'(wid_cnt), 32'd4);
      checkOutput("fill_empty", 32'(wid_empty), 32'd0);
      expOrder[0] = 8'h11; expOrder[1] = 8'h22; expOrder[2] = 8'h33; expOrder[3] = 8'h44;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
         checkOutput($sformatf("drain_wid%0d", i), 32'(wid), 32'(expOrder[i]));
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("drain_empty", 32'(wid_empty), 32'd1);
      checkOutput("drain_cnt", 32'(wid_cnt), 32'd0);

      // Overflow: refill, push without pop is dropped; push with pop while full is accepted.
      applyStimulus(1'b1, 8'hA0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
      checkOutput("ovf_pre_flag", 32'(wid_ovf_err), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("ovf_flag", 32'(wid_ovf_err), 32'd1);
      checkOutput("ovf_cnt", 32'(wid_cnt), 32'd4);
      checkOutput("ovf_head", 32'(wid), 32'hA0);
      applyStimulus(1'b1, 8'h66, 1'b1, 1'b0);
      checkOutput("full_pp_wid", 32'(wid), 32'hA0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("full_pp_cnt", 32'(wid_cnt), 32'd4);
      checkOutput("full_pp_full", 32'(wid_full), 32'd1);
      expOrder[0] = 8'hA1; expOrder[1] = 8'hA2; expOrder[2] = 8'hA3; expOrder[3] = 8'h66;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
         checkOutput($sformatf("ovf_drain_wid%0d", i), 32'(wid), 32'(expOrder[i]));
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("ovf_clr", 32'(wid_ovf_err), 32'd0);
      checkOutput("ovf_drain_empty", 32'(wid_empty), 32'd1);

      // Underflow, clear, and set-over-clear priority.
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("udf_flag", 32'(wid_udf_err), 32'd1);
      checkOutput("udf_cnt", 32'(wid_cnt), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("udf_clr", 32'(wid_udf_err), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("udf_set_wins", 32'(wid_udf_err), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("udf_clr2", 32'(wid_udf_err), 32'd0);

      // Wrap-around: hold cnt=2 through 10 push/pop pairs.
      applyStimulus(1'b1, 8'hF0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hF1, 1'b0, 1'b0);
      expOrder[0] = 8'hF0; expOrder[1] = 8'hF1;
      for (int i = 2; i < 10; i++) expOrder[i] = 8'(i - 2);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
         checkOutput($sformatf("wrap_wid%0d", i), 32'(wid), 32'(expOrder[i]));
         checkOutput($sformatf("wrap_cnt%0d", i), 32'(wid_cnt), 32'd2);
      end
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("wrap_tail0", 32'(wid), 32'h08);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("wrap_tail1", 32'(wid), 32'h09);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("wrap_empty", 32'(wid_empty), 32'd1);

      // Asynchronous reset mid-operation discards queued IDs.
      applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hB2, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hB3, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("midrst_pre_cnt", 32'(wid_cnt), 32'd3);
      #2;
      pad_cpu_rst_b = 1'b0;
      #1;
      checkOutput("midrst_cnt", 32'(wid_cnt), 32'd0);
      checkOutput("midrst_empty", 32'(wid_empty), 32'd1);
      checkOutput("midrst_wid", 32'(wid), 32'd0);
      @(negedge per_clk);
      pad_cpu_rst_b = 1'b1;
      applyStimulus(1'b1, 8'h7E, 1'b0, 1'b0);
      checkOutput("postrst_bypass", 32'(wid), 32'h7E);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("postrst_wid", 32'(wid), 32'h7E);
      checkOutput("postrst_cnt", 32'(wid_cnt), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("postrst_empty", 32'(wid_empty), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
